// File: rtl/adc_spi_sampler_pkg.sv
// -----------------------------------------------------------------------------
// adc_spi_sampler_pkg
// Shared definitions for the servo-pot SPI ADC sampler.
//   - adc_state_e    : sequencer state encoding (IDLE, SETUP, SHIFT, DONE, QUIET)
//   - ADC_FRAME_BITS : sclk cycles per ADC frame
//   - ADC_DATA_BITS  : LSBs of the frame that carry the conversion result
//   - ADC_OUT_W      : width of the presented sample word
// -----------------------------------------------------------------------------
package adc_spi_sampler_pkg;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_BITS  = 12;
    localparam int ADC_OUT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_QUIET = 3'd4
    } adc_state_e;

endpackage

// File: rtl/adc_spi_sampler_tick.sv
// -----------------------------------------------------------------------------
// adc_sclk_tick
// Half-period timer for the SPI sequencer. Counts 0..CLK_DIV-1 and wraps.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_restart  forces the count back to 0 (held while the sequencer is idle)
//   o_tick     last cycle of the current half-period
//   o_first    first cycle of the current half-period
// -----------------------------------------------------------------------------
module adc_sclk_tick #(
    parameter int CLK_DIV = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick,
    output logic o_first
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A restart cycle never ends a half-period: the phase after it starts fresh.
    assign o_tick  = w_last && !i_restart;
    assign o_first = (r_cnt == '0);

endmodule

// File: rtl/adc_spi_sampler.sv
// -----------------------------------------------------------------------------
// adc_spi_sampler
// Serial front-end for the 12-bit SPI ADC on the servo position pot. Once per
// SAMPLE_PERIOD it drops cs, clocks out FRAME_BITS sclk cycles (idle high),
// captures the frame MSB first and presents {4'b0, sample[11:0]} with a
// one-cycle data_valid strobe.
//
// Optional build macro: ADC_AVG4_EN
//   When defined, data is the mean of the last four samples (history cleared
//   on reset, missing entries count as 0) and the strobe comes one cycle later.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous active-high reset, aborts any frame in flight
//   i_sdata       ADC serial data, changes after sclk falling edge
//   i_enable      permits new frames to start
//   o_cs          ADC chip select, active low
//   o_sclk        serial clock, idles high
//   o_data        latest sample, zero-extended to 16 bits
//   o_data_valid  one-cycle strobe when o_data updates
//   o_busy        high in SETUP, SHIFT and DONE
//   o_dbg_state   current sequencer state
// -----------------------------------------------------------------------------
module adc_spi_sampler
    import adc_spi_sampler_pkg::*;
#(
    parameter int CLK_DIV       = 5,
    parameter int SAMPLE_PERIOD = 10000,
    parameter int FRAME_BITS    = ADC_FRAME_BITS,
    parameter int DATA_BITS     = ADC_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sdata,
    input  logic                 i_enable,
    output logic                 o_cs,
    output logic                 o_sclk,
    output logic [ADC_OUT_W-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_busy,
    output adc_state_e           o_dbg_state
);

    localparam int PW     = $clog2(SAMPLE_PERIOD);
    localparam int HW     = $clog2(2 * FRAME_BITS);
    localparam int PAD_W  = ADC_OUT_W - DATA_BITS;

    // ---------------------------------------------------------------------
    // Free-running sample period counter
    // ---------------------------------------------------------------------
    logic [PW-1:0] r_period;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period <= '0;
        end else if (r_period == PW'(SAMPLE_PERIOD - 1)) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Input synchroniser stage for the serial data line
    // ---------------------------------------------------------------------
    logic r_sdata_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sdata_q <= 1'b0;
        end else begin
            r_sdata_q <= i_sdata;
        end
    end

    // ---------------------------------------------------------------------
    // Half-period timer
    // ---------------------------------------------------------------------
    adc_state_e r_state;
    logic       w_restart;
    logic       w_tick;
    logic       w_first;

    // Holding the timer in IDLE and DONE lines up count 0 with the first
    // cycle of SETUP and of QUIET.
    assign w_restart = (r_state == ST_IDLE) || (r_state == ST_DONE);

    adc_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (w_restart),
        .o_tick    (w_tick),
        .o_first   (w_first)
    );

    // ---------------------------------------------------------------------
    // Sequencer, shift register and output registers
    // ---------------------------------------------------------------------
    logic [HW-1:0]        r_h;        // half-period index in SHIFT, tick count in QUIET
    // Only the data LSBs are kept; the leading frame bits fall off the top.
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_cs;
    logic                 r_sclk;
    logic                 r_busy;
    logic                 r_data_valid;
    logic [ADC_OUT_W-1:0] r_data;

    logic w_frame_start;
    logic w_sample;
    logic w_last_half;

    assign w_frame_start = (r_period == '0) && i_enable;
    // Sample on the first cycle of each sclk-high half-period (rising edge).
    assign w_sample      = (r_state == ST_SHIFT) && r_h[0] && w_first;
    assign w_last_half   = (r_h == HW'(2 * FRAME_BITS - 1));

`ifdef ADC_AVG4_EN
    logic [DATA_BITS-1:0] r_hist [4];
    logic [DATA_BITS+1:0] r_sum;
    logic [DATA_BITS+1:0] w_sum_next;

    // Running sum: add the newest sample, drop the one leaving the window.
    assign w_sum_next = r_sum + (DATA_BITS+2)'(r_shreg) - (DATA_BITS+2)'(r_hist[3]);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_h          <= '0;
            r_shreg      <= '0;
            r_cs         <= 1'b1;
            r_sclk       <= 1'b1;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
`ifdef ADC_AVG4_EN
            r_sum        <= '0;
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
`endif
        end else begin
            r_data_valid <= 1'b0;

            if (w_sample) begin
                r_shreg <= {r_shreg[DATA_BITS-2:0], r_sdata_q};
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= ST_SETUP;
                        r_cs    <= 1'b0;
                        r_sclk  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                        r_h     <= '0;
                        r_sclk  <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (w_tick) begin
                        if (w_last_half) begin
                            // cs/sclk/data are registered here so they are
                            // already visible during the DONE cycle.
                            r_state <= ST_DONE;
                            r_cs    <= 1'b1;
                            r_sclk  <= 1'b1;
`ifndef ADC_AVG4_EN
                            r_data       <= {{PAD_W{1'b0}}, r_shreg};
                            r_data_valid <= 1'b1;
`endif
                        end else begin
                            r_h    <= r_h + 1'b1;
                            // Next half-period index is odd when the current one is even.
                            r_sclk <= ~r_h[0];
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_QUIET;
                    r_busy  <= 1'b0;
                    r_h     <= '0;
`ifdef ADC_AVG4_EN
                    r_hist[0]    <= r_shreg;
                    r_hist[1]    <= r_hist[0];
                    r_hist[2]    <= r_hist[1];
                    r_hist[3]    <= r_hist[2];
                    r_sum        <= w_sum_next;
                    r_data       <= {{PAD_W{1'b0}}, w_sum_next[DATA_BITS+1:2]};
                    r_data_valid <= 1'b1;
`endif
                end

                ST_QUIET: begin
                    // Two half-periods of cs high before another frame may start.
                    if (w_tick) begin
                        if (r_h == HW'(1)) begin
                            r_state <= ST_IDLE;
                            r_h     <= '0;
                        end else begin
                            r_h <= r_h + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cs         = r_cs;
    assign o_sclk       = r_sclk;
    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_busy       = r_busy;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Serial front-end for the 12-bit SPI ADC on the servo position potentiometer.
- Generates cs and sclk, shifts in one 16-bit frame per sample period, and presents a zero-extended 16-bit sample with a 1-cycle valid strobe.
- Its output feeds the position (Pot) input and the receive-enable of the PID controller stage.

Parameters:
- CLK_DIV, 5: clk cycles per sclk half-period (100 MHz clk gives 10 MHz sclk); legal range >= 2.
- SAMPLE_PERIOD, 10000: clk cycles between frame starts (10 kHz); must be >= 35*CLK_DIV.
- FRAME_BITS, 16: sclk cycles per frame.
- DATA_BITS, 12: number of LSBs of the frame kept as data.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sdata  in  1  ADC serial data, MSB first; changes after sclk falling edge.
- enable  in  1  start of new frames is allowed while high.
- cs  out  1  ADC chip select, active low.
- sclk  out  1  serial clock, idles high.
- data  out  16  latest sample, {4'b0, data[11:0]}.
- data_valid  out  1  one-cycle strobe when data updates.
- busy  out  1  high from cs fall until DONE completes.

Behaviour:
- Reset (one clk edge with rst=1):
  - cs=1, sclk=1, data=0, data_valid=0, busy=0.
  - Period counter and state machine return to IDLE.
  - Applies immediately mid-frame; any partial shift is discarded.
- Period counter: free-running 0..SAMPLE_PERIOD-1 and wraps. A frame starts when the counter is 0, enable=1 and state=IDLE.
- sdata is registered once in clk (sdata_q) before it is used.
- State IDLE:
  - cs=1, sclk=1.
  - Go to SETUP on the start condition.
- State SETUP:
  - cs=0, sclk=1 for CLK_DIV cycles.
  - Then go to SHIFT with h=0.
- State SHIFT:
  - 2*FRAME_BITS half-periods, h=0..31, each CLK_DIV cycles long.
  - sclk=0 for even h and 1 for odd h.
  - On the first cycle of each odd h (rising edge), shift sdata_q into a 16-bit shift register from the LSB end.
  - After h=31 ends, go to DONE.
- State DONE (1 cycle):
  - cs=1, sclk=1.
  - data <= {4'b0, shreg[11:0]}; data_valid=1; go to QUIET.
- State QUIET:
  - cs=1 for 2*CLK_DIV cycles, then go to IDLE.
- Latency: the data_valid cycle follows the cs falling edge by exactly 33*CLK_DIV clk cycles (165 at default).
- busy is 1 in SETUP, SHIFT and DONE.
- enable deasserted mid-frame: the current frame completes normally; no new frame starts.
- enable asserted while the counter is nonzero: wait for the next counter wrap to 0.
- The 4 leading bits of the frame are ignored.
- data holds its value between strobes.

Optional Feature:
- Macro: ADC_AVG4_EN.
- When defined:
  - Keep a 4-entry history of 12-bit samples, cleared on reset.
  - Use a 14-bit running sum.
  - data = {4'b0, sum[13:2]} of the last 4 samples, still strobed in DONE.
  - Before 4 samples exist, the empty entries count as 0.
  - data_valid latency grows by 1 cycle.
- When undefined: raw sample output as specified above.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SETUP, SHIFT, DONE, QUIET);
  - constants ADC_FRAME_BITS=16, ADC_DATA_BITS=12, ADC_OUT_W=16.
- One natural sub-module: adc_sclk_tick, the CLK_DIV half-period tick generator with a restart input.
- Shift register, FSM and averager stay in the top module.

Test Plan:
- ADC model returns 0xABC in a 16-bit frame (leading 0000) -> data=0x0ABC, data_valid high exactly 1 cycle, 165 cycles after the cs fall.
- Run 3 frames -> 16 sclk rising edges per frame; sclk high whenever cs=1; data_valid pulses spaced exactly 10000 cycles.
- rst=1 for 1 cycle during SHIFT at h=10 -> next cycle cs=1, sclk=1, data=0, busy=0; next frame starts at the following counter wrap and returns the correct value.
- enable dropped at h=5 -> frame completes with valid data; no cs fall thereafter until enable returns.
- Model returns 0xFFF then 0x000 -> data=0x0FFF, then data=0x0000, with no residue from the previous frame.
- ADC_AVG4_EN, samples 400, 800, 1200, 1600 -> data=100, 300, 600, 1000.
